// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 frame constants, FSM state type and frame-building helper.
// Used by the transmitter; the receiver relies on the same bit-count constants.
package ps2_tx_pkg;

  localparam int NBITS      = 9;   // d0..d7 plus odd parity
  localparam int ACK_STROBE = 11;  // device ACK bit follows the stop bit

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_SEND    = 3'd2,
    ST_ACK     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] code);
    return {~^code, code};
  endfunction

endpackage

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, shift d0..d7/parity/stop, check ACK.
// Line updates are registered one cycle after each device clock strobe; tx_start is ignored while busy.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = 2400,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_ena,
  input  logic       ps2_dat_sync,
  input  logic [7:0] tx_code,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ackerr,
  output logic       tx_timeout,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               ackerr_q, ackerr_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ackerr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ackerr_q  <= ackerr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ackerr_d  = ackerr_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (tx_start) begin
          state_d   = ST_INHIBIT;
          shift_d   = frame_bits(tx_code);
          ackerr_d  = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = CW'(INHIBIT_CYC - 1);
          clk_oe_d  = 1'b1;
          dat_oe_d  = (INHIBIT_CYC == 1);
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_SEND;
          clk_oe_d = 1'b0;
          cnt_d    = CW'(TIMEOUT_CYC - 1);
          bitcnt_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // start bit goes low on the final inhibit cycle
          if (cnt_q == CW'(1)) dat_oe_d = 1'b1;
        end
      end

      ST_SEND, ST_ACK: begin
        if (ps2_clk_ena) begin
          cnt_d    = CW'(TIMEOUT_CYC - 1);
          bitcnt_d = bitcnt_q + 1'b1;
          if (state_q == ST_ACK) begin
            ackerr_d = ps2_dat_sync;
            state_d  = ST_DONE;
          end else if (bitcnt_q == 4'(ACK_STROBE - 2)) begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end else begin
            dat_oe_d = ~shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end else if (cnt_q == '0) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_busy    = (state_q == ST_INHIBIT) || (state_q == ST_SEND) || (state_q == ST_ACK);
  assign tx_done    = (state_q == ST_DONE);
  assign tx_ackerr  = ackerr_q;
  assign tx_timeout = timeout_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: random bytes and gaps, device modelled as strobes plus an ACK level,
// expected line levels computed from the frame rules (LSB first, odd parity, stop released).
module tb_ps2_tx;

  localparam int INH = 8;
  localparam int TMO = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk_ena = 1'b0;
  logic       ps2_dat_sync = 1'b1;
  logic [7:0] tx_code = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_ackerr, tx_timeout, ps2_clk_oe, ps2_dat_oe;

  int total = 0;
  int bad   = 0;

  ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_ena  (ps2_clk_ena),
    .ps2_dat_sync (ps2_dat_sync),
    .tx_code      (tx_code),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_ackerr    (tx_ackerr),
    .tx_timeout   (tx_timeout),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_dat_oe   (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic dat);
    ps2_dat_sync = dat;
    ps2_clk_ena  = 1'b1;
    tick();
    ps2_clk_ena  = 1'b0;
    ps2_dat_sync = 1'($urandom_range(0, 1));
  endtask

  // Pull-low enable expected after strobe n (1..10): data bits LSB first, odd parity, stop released.
  function automatic logic exp_oe(input logic [7:0] code, input int n);
    if (n <= 8) return ~code[n-1];
    if (n == 9) return ($countones(code) % 2) == 1;
    return 1'b0;
  endfunction

  // mode 0: device ACKs, 1: device leaves data high, 2: device stops clocking after strobe 4
  task automatic run_frame(input logic [7:0] code, input int mode, input bit noise);
    int cnt;
    tx_code  = code;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_code  = 8'($urandom);
    chk("accept_busy", 32'(tx_busy), 1);
    chk("accept_ackerr_clr", 32'(tx_ackerr), 0);
    chk("accept_timeout_clr", 32'(tx_timeout), 0);
    for (int i = 1; i <= INH; i++) begin
      chk("inhibit_clk_oe", 32'(ps2_clk_oe), 1);
      chk("inhibit_dat_oe", 32'(ps2_dat_oe), 32'(i == INH));
      if (noise) ps2_clk_ena = 1'($urandom_range(0, 1));
      if (noise && i == 3) tx_start = 1'b1;
      tick();
      ps2_clk_ena = 1'b0;
      tx_start    = 1'b0;
    end
    chk("rts_clk_released", 32'(ps2_clk_oe), 0);
    chk("rts_start_bit", 32'(ps2_dat_oe), 1);
    for (int n = 1; n <= 11; n++) begin
      if (mode == 2 && n == 5) break;
      repeat ($urandom_range(1, 6)) begin
        if (noise && n <= 10) tx_start = 1'($urandom_range(0, 1));
        tick();
        tx_start = 1'b0;
      end
      if (n == 1) chk("start_bit_held", 32'(ps2_dat_oe), 1);
      strobe(n == 11 ? (mode == 1) : 1'($urandom_range(0, 1)));
      if (n <= 10) begin
        chk($sformatf("bit%0d_dat_oe", n), 32'(ps2_dat_oe), 32'(exp_oe(code, n)));
        chk("send_busy", 32'(tx_busy), 1);
        chk("send_no_done", 32'(tx_done), 0);
      end
    end
    if (mode != 2) begin
      chk("done_pulse", 32'(tx_done), 1);
      chk("done_busy_low", 32'(tx_busy), 0);
      chk("done_ackerr", 32'(tx_ackerr), 32'(mode == 1));
      chk("done_timeout", 32'(tx_timeout), 0);
      chk("done_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    end else begin
      cnt = 0;
      while (!tx_done && cnt < TMO + 20) begin
        tick();
        cnt++;
      end
      chk("timeout_latency", 32'(cnt), 32'(TMO));
      chk("timeout_flag", 32'(tx_timeout), 1);
      chk("timeout_ackerr", 32'(tx_ackerr), 0);
      chk("timeout_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
      chk("timeout_busy_low", 32'(tx_busy), 0);
    end
    tick();
    chk("done_one_cycle", 32'(tx_done), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_busy", 32'(tx_busy), 0);
    chk("reset_done", 32'(tx_done), 0);
    chk("reset_flags", {30'd0, tx_ackerr, tx_timeout}, 0);
    chk("reset_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    rst = 1'b1;
    tick();

    repeat (5) begin
      strobe(1'($urandom_range(0, 1)));
      tick();
    end
    chk("idle_strobe_busy", 32'(tx_busy), 0);
    chk("idle_strobe_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("idle_strobe_done", 32'(tx_done), 0);

    run_frame(8'hED, 0, 1'b0);
    run_frame(8'h00, 0, 1'b1);
    run_frame(8'hFF, 0, 1'b1);

    run_frame(8'($urandom), 1, 1'b0);
    repeat (5) tick();
    chk("ackerr_held", 32'(tx_ackerr), 1);
    run_frame(8'($urandom), 0, 1'b0);

    run_frame(8'($urandom), 2, 1'b0);
    repeat (4) tick();
    chk("timeout_held", 32'(tx_timeout), 1);

    repeat (4) run_frame(8'($urandom), 0, 1'b1);

    tx_code  = 8'h00;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (INH) tick();
    repeat (3) begin
      tick();
      strobe(1'b1);
    end
    chk("pre_reset_dat_low", 32'(ps2_dat_oe), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("async_reset_busy", 32'(tx_busy), 0);
    chk("async_reset_done", 32'(tx_done), 0);
    repeat (3) begin
      tick();
      chk("reset_no_done", 32'(tx_done), 0);
    end
    rst = 1'b1;
    tick();
    run_frame(8'($urandom), 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
